// File: rtl/fxp_series_accumulator.sv
// fxp_series_accumulator
//   Streams signed fixed-point terms into a running sum and hands out one
//   result per stream. Each term is added or subtracted, with optional
//   saturation (SATURATE=1) or modulo-2^N wrap (SATURATE=0), and a sticky
//   overflow flag.
//
// Ports
//   clk, rst       rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_sub/in_last   term stream (one term/cycle)
//   out_valid/out_ready                        result handshake
//   out_data       accumulated sum (running acc outside HOLD)
//   out_overflow   some term in this stream overflowed
//   out_terms      terms accepted in this stream, saturating at 2^CNT_W-1
module fxp_series_accumulator #(
  parameter int N        = 16,
  parameter int FRAC     = 11,
  parameter int SATURATE = 1,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_sub,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic             out_overflow,
  output logic [CNT_W-1:0] out_terms
);

  // FRAC only documents the format; the arithmetic never looks at it.
  if (FRAC < 0 || FRAC >= N) begin : g_frac_chk
    $error("FRAC must lie in [0, N-1]");
  end

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [N-1:0] MAXV = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MINV = {1'b1, {(N-1){1'b0}}};

  state_t            state, state_nxt;
  logic [N-1:0]      acc, acc_nxt;
  logic              ovf, ovf_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;

  logic [N:0]        opa, opb, sum;
  logic              beat_ovf;
  logic [N-1:0]      beat_res;
  logic              acpt, take;

  // Handshake decode depends on state (and rst) only.
  assign in_ready  = !rst && (state == ACCUM);
  assign out_valid = (state == HOLD);

  assign acpt = in_valid && in_ready;
  assign take = out_valid && out_ready;

  // One guard bit is enough: the N+1-bit sum of two N-bit values never wraps.
  assign opa      = {acc[N-1], acc};
  assign opb      = {in_data[N-1], in_data};
  assign sum      = in_sub ? (opa - opb) : (opa + opb);
  assign beat_ovf = sum[N] ^ sum[N-1];

  always_comb begin
    beat_res = sum[N-1:0];
    if (SATURATE != 0 && beat_ovf)
      beat_res = sum[N] ? MINV : MAXV;  // guard bit holds the true sign
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    ovf_nxt   = ovf;
    cnt_nxt   = cnt;
    case (state)
      ACCUM: begin
        if (acpt) begin
          acc_nxt = beat_res;
          ovf_nxt = ovf | beat_ovf;
          if (cnt != {CNT_W{1'b1}}) cnt_nxt = cnt + 1'b1;
          if (in_last) state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (take) begin
          acc_nxt   = '0;
          ovf_nxt   = 1'b0;
          cnt_nxt   = '0;
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      ovf   <= ovf_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign out_data     = acc;
  assign out_overflow = ovf;
  assign out_terms    = cnt;

endmodule

// File: tb/tb_fxp_series_accumulator.sv
// Directed bench for fxp_series_accumulator. Three instances share one input
// stream: saturating (u_sat), wrapping (u_wrap) and a 2-bit term counter
// (u_c2). Inputs change and outputs are sampled on the falling edge.
module tb_fxp_series_accumulator;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_sub, in_last, out_ready;
  logic [15:0] in_data;

  logic        rdy_s, vld_s, ovf_s;
  logic [15:0] dat_s;
  logic [7:0]  trm_s;
  logic        rdy_w, vld_w, ovf_w;
  logic [15:0] dat_w;
  logic [7:0]  trm_w;
  logic        rdy_c, vld_c, ovf_c;
  logic [15:0] dat_c;
  logic [1:0]  trm_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fxp_series_accumulator #(.N(16), .FRAC(11), .SATURATE(1), .CNT_W(8)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s),
    .in_data(in_data), .in_sub(in_sub), .in_last(in_last),
    .out_valid(vld_s), .out_ready(out_ready), .out_data(dat_s),
    .out_overflow(ovf_s), .out_terms(trm_s));

  fxp_series_accumulator #(.N(16), .FRAC(11), .SATURATE(0), .CNT_W(8)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w),
    .in_data(in_data), .in_sub(in_sub), .in_last(in_last),
    .out_valid(vld_w), .out_ready(out_ready), .out_data(dat_w),
    .out_overflow(ovf_w), .out_terms(trm_w));

  fxp_series_accumulator #(.N(16), .FRAC(11), .SATURATE(1), .CNT_W(2)) u_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_c),
    .in_data(in_data), .in_sub(in_sub), .in_last(in_last),
    .out_valid(vld_c), .out_ready(out_ready), .out_data(dat_c),
    .out_overflow(ovf_c), .out_terms(trm_c));

  // One accepted beat: drive at a falling edge, expect ready, advance a cycle.
  task automatic beat(input logic [15:0] d, input logic sub, input logic last);
    in_valid = 1'b1; in_data = d; in_sub = sub; in_last = last;
    #1;
    total++; if (rdy_s !== 1'b1) begin bad++; $display("FAIL beat_ready got=%b want=1", rdy_s); end
    @(negedge clk);
    in_valid = 1'b0; in_sub = 1'b0; in_last = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Consume the result held in HOLD.
  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sub = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    idle(2);
    total++; if (rdy_s !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", rdy_s); end
    total++; if (vld_s !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", vld_s); end
    total++; if (dat_s !== 16'h0000) begin bad++; $display("FAIL rst_out_data got=%h want=0000", dat_s); end
    total++; if (ovf_s !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b want=0", ovf_s); end
    total++; if (trm_s !== 8'd0) begin bad++; $display("FAIL rst_terms got=%0d want=0", trm_s); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (rdy_s !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b want=1", rdy_s); end
  endtask

  task automatic test_basic();
    beat(16'h0800, 1'b0, 1'b0);
    total++; if (vld_s !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b want=0", vld_s); end
    beat(16'h0400, 1'b0, 1'b0);
    beat(16'h0200, 1'b1, 1'b1);
    total++; if (vld_s !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", vld_s); end
    total++; if (rdy_s !== 1'b0) begin bad++; $display("FAIL basic_hold_ready got=%b want=0", rdy_s); end
    total++; if (dat_s !== 16'h0A00) begin bad++; $display("FAIL basic_data got=%h want=0a00", dat_s); end
    total++; if (dat_w !== 16'h0A00) begin bad++; $display("FAIL basic_data_wrap got=%h want=0a00", dat_w); end
    total++; if (trm_s !== 8'd3) begin bad++; $display("FAIL basic_terms got=%0d want=3", trm_s); end
    total++; if (ovf_s !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%b want=0", ovf_s); end
    take();
    total++; if (rdy_s !== 1'b1) begin bad++; $display("FAIL basic_ready_after got=%b want=1", rdy_s); end
    total++; if (vld_s !== 1'b0) begin bad++; $display("FAIL basic_valid_after got=%b want=0", vld_s); end
    total++; if (dat_s !== 16'h0000) begin bad++; $display("FAIL basic_acc_clear got=%h want=0000", dat_s); end
    total++; if (trm_s !== 8'd0) begin bad++; $display("FAIL basic_cnt_clear got=%0d want=0", trm_s); end
  endtask

  task automatic test_pos_overflow();
    beat(16'h7000, 1'b0, 1'b0);
    beat(16'h7000, 1'b0, 1'b1);
    total++; if (dat_s !== 16'h7FFF) begin bad++; $display("FAIL posovf_sat got=%h want=7fff", dat_s); end
    total++; if (ovf_s !== 1'b1) begin bad++; $display("FAIL posovf_sat_flag got=%b want=1", ovf_s); end
    total++; if (dat_w !== 16'hE000) begin bad++; $display("FAIL posovf_wrap got=%h want=e000", dat_w); end
    total++; if (ovf_w !== 1'b1) begin bad++; $display("FAIL posovf_wrap_flag got=%b want=1", ovf_w); end
    take();
    total++; if (ovf_s !== 1'b0) begin bad++; $display("FAIL posovf_flag_clear got=%b want=0", ovf_s); end
  endtask

  task automatic test_neg_boundary();
    beat(16'h8000, 1'b0, 1'b0);
    beat(16'h0001, 1'b1, 1'b1);
    total++; if (dat_s !== 16'h8000) begin bad++; $display("FAIL neg_sat got=%h want=8000", dat_s); end
    total++; if (ovf_s !== 1'b1) begin bad++; $display("FAIL neg_sat_flag got=%b want=1", ovf_s); end
    total++; if (dat_w !== 16'h7FFF) begin bad++; $display("FAIL neg_wrap got=%h want=7fff", dat_w); end
    take();
    beat(16'h8000, 1'b1, 1'b1);
    total++; if (dat_s !== 16'h7FFF) begin bad++; $display("FAIL negmin_sat got=%h want=7fff", dat_s); end
    total++; if (ovf_s !== 1'b1) begin bad++; $display("FAIL negmin_flag got=%b want=1", ovf_s); end
    total++; if (dat_w !== 16'h8000) begin bad++; $display("FAIL negmin_wrap got=%h want=8000", dat_w); end
    take();
  endtask

  task automatic test_backpressure();
    beat(16'h0300, 1'b0, 1'b1);
    in_valid = 1'b1; in_data = 16'h1234; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (rdy_s !== 1'b0) begin bad++; $display("FAIL bp_ready[%0d] got=%b want=0", i, rdy_s); end
      total++; if (vld_s !== 1'b1 || dat_s !== 16'h0300 || trm_s !== 8'd1)
        begin bad++; $display("FAIL bp_hold[%0d] got=%b/%h/%0d want=1/0300/1", i, vld_s, dat_s, trm_s); end
    end
    in_valid = 1'b0; in_last = 1'b0;
    take();
    beat(16'h0100, 1'b0, 1'b1);
    total++; if (dat_s !== 16'h0100) begin bad++; $display("FAIL bp_next_data got=%h want=0100", dat_s); end
    total++; if (trm_s !== 8'd1) begin bad++; $display("FAIL bp_next_terms got=%0d want=1", trm_s); end
    take();
  endtask

  task automatic test_reset_midstream();
    beat(16'h0800, 1'b0, 1'b0);
    beat(16'h0800, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    total++; if (rdy_s !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%b want=0", rdy_s); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (dat_s !== 16'h0000) begin bad++; $display("FAIL midrst_acc got=%h want=0000", dat_s); end
    beat(16'h0200, 1'b0, 1'b1);
    total++; if (dat_s !== 16'h0200) begin bad++; $display("FAIL midrst_data got=%h want=0200", dat_s); end
    total++; if (trm_s !== 8'd1) begin bad++; $display("FAIL midrst_terms got=%0d want=1", trm_s); end
    total++; if (ovf_s !== 1'b0) begin bad++; $display("FAIL midrst_ovf got=%b want=0", ovf_s); end
    // Reset while a result is pending drops it.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (vld_s !== 1'b0 || rdy_s !== 1'b1) begin bad++; $display("FAIL holdrst got=%b/%b want=0/1", vld_s, rdy_s); end
  endtask

  task automatic test_gaps_and_count();
    beat(16'h0100, 1'b0, 1'b0);
    idle(2);
    beat(16'h0200, 1'b0, 1'b0);
    idle(1);
    beat(16'h0300, 1'b0, 1'b1);
    total++; if (dat_s !== 16'h0600) begin bad++; $display("FAIL gap_data got=%h want=0600", dat_s); end
    total++; if (trm_s !== 8'd3) begin bad++; $display("FAIL gap_terms got=%0d want=3", trm_s); end
    take();
    for (int i = 0; i < 5; i++) beat(16'h0010, 1'b0, (i == 4));
    total++; if (dat_c !== 16'h0050) begin bad++; $display("FAIL cnt_data got=%h want=0050", dat_c); end
    total++; if (trm_c !== 2'd3) begin bad++; $display("FAIL cnt_sat got=%0d want=3", trm_c); end
    total++; if (trm_s !== 8'd5) begin bad++; $display("FAIL cnt_wide got=%0d want=5", trm_s); end
    take();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sub = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_pos_overflow();
    test_neg_boundary();
    test_backpressure();
    test_reset_midstream();
    test_gaps_and_count();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog: the directed sequence is a few hundred cycles at most.
  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fxp_series_accumulator.md
# fxp_series_accumulator

Parametrised, handshaked, signed fixed-point accumulator that sums a stream of terms into one result. Each term is added or subtracted, with optional saturation and a sticky overflow flag. It succeeds the plain combinational adder in the cosine datapath: a series evaluator (e.g. Taylor terms) streams terms in and receives one summed result per stream. Default format is Q5.11 in 16 bits.

## Interface
- `N`, 16, total data width, two's-complement signed.
- `FRAC`, 11, fraction bits. Informational only; the arithmetic is format-agnostic.
- `SATURATE`, 1: 1 clamps on overflow, 0 wraps modulo 2^N.
- `CNT_W`, 8, width of the term counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  term present.
- `in_ready`  out  1  block accepts a term this cycle.
- `in_data`  in  N  signed term.
- `in_sub`  in  1  1 means subtract the term, 0 means add it.
- `in_last`  in  1  final term of the stream.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `out_data`  out  N  signed accumulated result.
- `out_overflow`  out  1  at least one term in this stream overflowed.
- `out_terms`  out  CNT_W  number of terms accepted in this stream.

## Operation
- States: ACCUM and HOLD. Reset enters ACCUM.
- Register reset values: acc=0, ovf=0, cnt=0.
- Output reset values: out_valid=0, out_data=0, out_overflow=0, out_terms=0.
- ACCUM:
  - in_ready=1, out_valid=0.
  - A term is accepted when in_valid and in_ready are both high.
  - On an accepted term: acc <= f(acc ± in_data), cnt <= cnt+1, ovf <= ovf | overflow_this_beat.
  - If the accepted term has in_last=1, go to HOLD. That last term is included in the result.
- HOLD:
  - in_ready=0, out_valid=1.
  - out_data=acc, out_overflow=ovf, out_terms=cnt. All held stable.
  - On out_valid and out_ready: acc, ovf and cnt clear to 0 and the state returns to ACCUM.
- Arithmetic:
  - Sign-extend both operands to N+1 bits, then compute sum = acc + in_data or acc − in_data. N+1 bits is always sufficient.
  - Overflow occurs when sum > 2^(N−1)−1 or sum < −2^(N−1).
  - SATURATE=1: clamp to 2^(N−1)−1 or −2^(N−1) respectively.
  - SATURATE=0: keep sum[N−1:0].
  - The overflow flag is set in both modes.
- Term counter saturates at 2^CNT_W−1 and never wraps.
- in_sub and in_last are sampled only on accepted beats. They are ignored when in_valid=0.
- Reset mid-stream or mid-HOLD:
  - Any partial sum or pending result is discarded.
  - All state returns to reset values on the next edge.
  - The next stream starts from 0.

## Timing
- in_ready and out_valid are decoded combinationally from the state register only. There are no combinational paths from in_valid or out_ready.
- While rst is high, in_ready=0 is forced. in_ready is 1 in the first cycle after rst falls.
- Throughput in ACCUM is one term per cycle.
- Latency: out_valid rises in the cycle after the edge that accepted the in_last term.
- Minimum stream period is number of terms + 1 cycles, since HOLD lasts at least one cycle.
- A result consumed in cycle t gives in_ready=1 in cycle t+1. There is no overlap between a result handoff and the first term of the next stream.
- out_data, out_overflow and out_terms are valid only while out_valid=1. Outside HOLD they show the running acc, ovf and cnt.

## Test plan
- Basic sum, Q5.11, SATURATE=1:
  - Stimulus: +0x0800 (1.0), +0x0400 (0.5), −0x0200 (0.25, in_sub=1, in_last=1).
  - Required: out_data=0x0A00 (1.25), out_terms=3, out_overflow=0, out_valid one cycle after the last accept.
- Positive overflow:
  - Stimulus: +0x7000, then +0x7000 with in_last.
  - SATURATE=1: out_data=0x7FFF, out_overflow=1.
  - SATURATE=0 instance: out_data=0xE000, out_overflow=1.
- Negative boundary:
  - Stimulus: +0x8000, then −0x0001 with in_last.
  - SATURATE=1: out_data=0x8000, out_overflow=1.
  - Also check the single-term stream −0x8000 (in_sub=1, in_last=1): out_data=0x7FFF, out_overflow=1.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in HOLD, with in_valid=1 throughout.
  - Required: in_ready=0, outputs stable, no term absorbed.
  - Release out_ready, then stream +0x0100 with in_last: out_data=0x0100, out_terms=1.
- Reset mid-stream:
  - Stimulus: accept +0x0800 and +0x0800, pulse rst for 1 cycle, then stream +0x0200 with in_last.
  - Required: out_data=0x0200, out_terms=1, out_overflow=0, in_ready=0 during rst.
- Gapped input and counter saturation:
  - Stimulus: terms with in_valid idle gaps, plus a CNT_W=2 instance fed 5 terms.
  - Required: the sum is unaffected by the gaps, and out_terms=3 (saturated) on the CNT_W=2 instance.
